// File: rtl/rem_serial_sequencer_pkg.sv
// rtl/rem_serial_sequencer_pkg.sv - shared state encodings and constant helpers for the remainder sequencer
package rem_serial_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rem_serial_sequencer_mod_step.sv
// rtl/rem_serial_sequencer_mod_step.sv - registered bit-serial remainder step: r <= (2r + b) mod MOD
module rem_mod_step #(
   parameter int MOD = 3,
   parameter int RW  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          bit_in,
   output logic [RW-1:0] rem
);

   logic [RW:0] sum;

   // 2r+b never exceeds 2*MOD-1, so one conditional subtract is enough
   always_comb begin
      sum = {rem, bit_in};
      if (sum >= (RW+1)'(MOD)) sum = sum - (RW+1)'(MOD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rem <= '0;
      else if (clr)  rem <= '0;
      else if (en)   rem <= sum[RW-1:0];
   end

endmodule

// File: rtl/rem_serial_sequencer.sv
// rtl/rem_serial_sequencer.sv - word-to-bit-serial mod-MOD reduction sequencer
// Optional LSB-first feeding with a weight register: REM_SEQ_LSB_MODE_EN.
module rem_serial_sequencer
   import rem_serial_sequencer_pkg::*;
#(
   parameter int W   = 8,
   parameter int MOD = 3,
   parameter int RW  = 2
) (
   input  logic          clk,
   input  logic          rst,
`ifdef REM_SEQ_LSB_MODE_EN
   input  logic          lsb_mode,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_word,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_rem,
   output logic          ser_valid,
   output logic          ser_bit
);

   localparam int CW = clog2(W);

   generate
      if (W < 2 || MOD < 2 || MOD > 255 || (1 << RW) < MOD) begin : g_bad_params
         $error("rem_serial_sequencer: illegal W/MOD/RW combination");
      end
   endgenerate

   state_t          state, state_next;
   logic            accept;
   logic            step_en;
   logic [W-1:0]    sreg;
   logic [CW-1:0]   count;
   logic [RW-1:0]   step_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      ser_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            ser_valid = 1'b1;
            if (count == '0) state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign step_en = (state == ST_SHIFT);

`ifdef REM_SEQ_LSB_MODE_EN
   logic          lsb;
   logic [RW-1:0] pw;
   logic [RW-1:0] lsb_rem;
   logic [RW:0]   pw_dbl;
   logic [RW:0]   lsb_sum;

   assign ser_bit = step_en ? (lsb ? sreg[0] : sreg[W-1]) : 1'b0;
   assign out_rem = (state == ST_DONE) ? (lsb ? lsb_rem : step_rem) : '0;

   // pw tracks 2^i mod MOD for the bit currently being fed
   always_comb begin
      pw_dbl = {pw, 1'b0};
      if (pw_dbl >= (RW+1)'(MOD)) pw_dbl = pw_dbl - (RW+1)'(MOD);
      lsb_sum = {1'b0, lsb_rem} + (ser_bit ? {1'b0, pw} : '0);
      if (lsb_sum >= (RW+1)'(MOD)) lsb_sum = lsb_sum - (RW+1)'(MOD);
   end
`else
   assign ser_bit = step_en ? sreg[W-1] : 1'b0;
   assign out_rem = (state == ST_DONE) ? step_rem : '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg    <= '0;
         count   <= '0;
`ifdef REM_SEQ_LSB_MODE_EN
         lsb     <= 1'b0;
         pw      <= '0;
         lsb_rem <= '0;
`endif
      end else if (accept) begin
         sreg    <= in_word;
         count   <= CW'(W - 1);
`ifdef REM_SEQ_LSB_MODE_EN
         lsb     <= lsb_mode;
         pw      <= RW'(1);
         lsb_rem <= '0;
`endif
      end else if (step_en) begin
         count   <= count - 1'b1;
`ifdef REM_SEQ_LSB_MODE_EN
         sreg    <= lsb ? (sreg >> 1) : (sreg << 1);
         pw      <= pw_dbl[RW-1:0];
         lsb_rem <= lsb_sum[RW-1:0];
`else
         sreg    <= sreg << 1;
`endif
      end
   end

   rem_mod_step #(
      .MOD (MOD),
      .RW  (RW)
   ) u_step (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (step_en),
      .bit_in (ser_bit),
      .rem    (step_rem)
   );

endmodule

// File: tb/tb_rem_serial_sequencer.sv
// tb/tb_rem_serial_sequencer.sv - directed self-checking bench for rem_serial_sequencer (MOD=3 and MOD=5)
module tb_rem_serial_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_word;
   logic       out_ready;
   logic       lsb_mode;

   logic       a_in_ready, a_out_valid, a_ser_valid, a_ser_bit;
   logic [1:0] a_out_rem;
   logic       b_in_ready, b_out_valid, b_ser_valid, b_ser_bit;
   logic [2:0] b_out_rem;

   int nchecks = 0;
   int nfail   = 0;

   always #5 clk = ~clk;

   rem_serial_sequencer #(.W(8), .MOD(3), .RW(2)) dut_a (
      .clk       (clk),
      .rst       (rst),
`ifdef REM_SEQ_LSB_MODE_EN
      .lsb_mode  (lsb_mode),
`endif
      .in_valid  (in_valid),
      .in_ready  (a_in_ready),
      .in_word   (in_word),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .out_rem   (a_out_rem),
      .ser_valid (a_ser_valid),
      .ser_bit   (a_ser_bit)
   );

   rem_serial_sequencer #(.W(8), .MOD(5), .RW(3)) dut_b (
      .clk       (clk),
      .rst       (rst),
`ifdef REM_SEQ_LSB_MODE_EN
      .lsb_mode  (lsb_mode),
`endif
      .in_valid  (in_valid),
      .in_ready  (b_in_ready),
      .in_word   (in_word),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .out_rem   (b_out_rem),
      .ser_valid (b_ser_valid),
      .ser_bit   (b_ser_bit)
   );

   // Offers one word from IDLE, records the fed bit stream and cycles to out_valid
   task automatic run(input logic sel, input logic [7:0] w,
                      output logic [7:0] bits, output logic [2:0] rem, output int lat);
      int k;
      k    = 0;
      bits = '0;
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = w;
      @(negedge clk);
      in_valid = 1'b0;
      while (!(sel ? b_out_valid : a_out_valid) && k < 40) begin
         if (sel ? b_ser_valid : a_ser_valid)
            bits = {bits[6:0], (sel ? b_ser_bit : a_ser_bit)};
         @(negedge clk);
         k++;
      end
      lat = k;
      rem = sel ? b_out_rem : {1'b0, a_out_rem};
      if (k >= 40) begin
         nchecks++;
         nfail++;
         $display("FAIL timeout word=%02h: out_valid never rose", w);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1; lsb_mode = 1'b0;
      #12;
      nchecks++;
      if ({a_in_ready, a_out_valid, a_ser_valid, a_ser_bit, a_out_rem} !== 6'b100000) begin
         nfail++;
         $display("FAIL reset_a: got rdy/ov/sv/sb/rem=%b required 100000",
                  {a_in_ready, a_out_valid, a_ser_valid, a_ser_bit, a_out_rem});
      end
      nchecks++;
      if ({b_in_ready, b_out_valid, b_ser_valid, b_out_rem} !== 6'b100000) begin
         nfail++;
         $display("FAIL reset_b: got %b required 100000",
                  {b_in_ready, b_out_valid, b_ser_valid, b_out_rem});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_msb_basic();
      logic [7:0] bits; logic [2:0] rem; int lat;
      run(1'b0, 8'hFF, bits, rem, lat);
      nchecks++;
      if (bits !== 8'hFF) begin nfail++; $display("FAIL ff_bits: got %b required 11111111", bits); end
      nchecks++;
      if (rem !== 3'd0) begin nfail++; $display("FAIL ff_rem: got %0d required 0", rem); end
      nchecks++;
      if (lat !== 8) begin nfail++; $display("FAIL ff_latency: got %0d required 8", lat); end
      @(negedge clk);
      nchecks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         nfail++;
         $display("FAIL idle_after_done: got in_ready=%b out_valid=%b required 1 0", a_in_ready, a_out_valid);
      end
      run(1'b0, 8'h80, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd2) begin nfail++; $display("FAIL h80_rem: got %0d required 2", rem); end
      run(1'b0, 8'h0A, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd1) begin nfail++; $display("FAIL h0a_rem: got %0d required 1", rem); end
      nchecks++;
      if (bits !== 8'b00001010) begin nfail++; $display("FAIL h0a_bits: got %b required 00001010", bits); end
   endtask

   task automatic test_backpressure();
      logic [7:0] bits; logic [2:0] rem; int lat;
      out_ready = 1'b0;
      run(1'b0, 8'h0D, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd1) begin nfail++; $display("FAIL bp_rem: got %0d required 1", rem); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_word  = 8'h02;
         nchecks++;
         if (a_out_valid !== 1'b1 || a_out_rem !== 2'd1 || a_in_ready !== 1'b0) begin
            nfail++;
            $display("FAIL bp_hold cycle %0d: got ov=%b rem=%0d rdy=%b required 1 1 0",
                     i, a_out_valid, a_out_rem, a_in_ready);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      nchecks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         nfail++;
         $display("FAIL bp_release: got ov=%b rdy=%b required 0 1", a_out_valid, a_in_ready);
      end
      run(1'b0, 8'h04, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd1 || bits !== 8'h04) begin
         nfail++;
         $display("FAIL bp_next: got rem=%0d bits=%02h required 1 04", rem, bits);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [7:0] bits; logic [2:0] rem; int lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      nchecks++;
      if (a_out_valid !== 1'b0 || a_ser_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         nfail++;
         $display("FAIL mid_reset: got ov=%b sv=%b rdy=%b required 0 0 1",
                  a_out_valid, a_ser_valid, a_in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      run(1'b0, 8'h05, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd2 || lat !== 8) begin
         nfail++;
         $display("FAIL after_reset_h05: got rem=%0d lat=%0d required 2 8", rem, lat);
      end
   endtask

   task automatic test_mod5();
      logic [7:0] bits; logic [2:0] rem; int lat;
      logic [7:0] w;
      run(1'b1, 8'hC8, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd0) begin nfail++; $display("FAIL m5_hc8: got %0d required 0", rem); end
      run(1'b1, 8'h7B, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd3 || bits !== 8'h7B) begin
         nfail++;
         $display("FAIL m5_h7b: got rem=%0d bits=%02h required 3 7b", rem, bits);
      end
      for (int i = 0; i < 200; i++) begin
         w = 8'($urandom_range(0, 255));
         run(1'b1, w, bits, rem, lat);
         nchecks++;
         if (rem !== 3'(w % 5) || {1'b0, a_out_rem} !== 3'(w % 3)) begin
            nfail++;
            $display("FAIL random word=%0d: got m5=%0d m3=%0d required %0d %0d",
                     w, rem, a_out_rem, w % 5, w % 3);
         end
      end
   endtask

`ifdef REM_SEQ_LSB_MODE_EN
   task automatic test_lsb_mode();
      logic [7:0] bits; logic [2:0] rem; int lat;
      lsb_mode = 1'b1;
      run(1'b1, 8'h7B, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd3 || bits !== 8'hDE || lat !== 8) begin
         nfail++;
         $display("FAIL lsb_h7b: got rem=%0d bits=%02h lat=%0d required 3 de 8", rem, bits, lat);
      end
      run(1'b1, 8'h0A, bits, rem, lat);
      nchecks++;
      if (rem !== 3'd0 || bits !== 8'h50 || a_out_rem !== 2'd1) begin
         nfail++;
         $display("FAIL lsb_h0a: got m5=%0d bits=%02h m3=%0d required 0 50 1", rem, bits, a_out_rem);
      end
      lsb_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_msb_basic();
      test_backpressure();
      test_reset_mid_shift();
      test_mod5();
`ifdef REM_SEQ_LSB_MODE_EN
      test_lsb_mode();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule
